// File: rtl/fun_inv_pkg.sv
// Shared constants for the a^3 + b^2 function unit: FSM state codes and widths.
package fun_pkg;

   localparam int FUN_W  = 8;
   localparam int FUN_YW = 3 * FUN_W + 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SQ_B = 3'd1;
   localparam logic [2:0] SQ_A = 3'd2;
   localparam logic [2:0] CU_A = 3'd3;
   localparam logic [2:0] ADD  = 3'd4;

endpackage

// File: rtl/fun_inv_if.sv
// Start/busy request bundle of the a^3 + b^2 unit; master drives operands and start.
interface fun_inv_if #(parameter int W = fun_pkg::FUN_W);

   logic [W-1:0] a_bi;
   logic [W-1:0] b_bi;
   logic         start_i;
   logic         busy_o;
   logic [3*W:0] y_bo;

   modport master (output a_bi, output b_bi, output start_i,
                   input  busy_o, input y_bo);
   modport slave  (input  a_bi, input  b_bi, input  start_i,
                   output busy_o, output y_bo);

endinterface

// File: rtl/fun_inv_mul_shadd.sv
// Sequential shift-add multiplier datapath; one partial product per step.
module mul_shadd
   import fun_pkg::*;
#(
   parameter int W = FUN_W
)
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load,
   input  logic           step,
   input  logic [3*W-1:0] ld_mcand,
   input  logic [W-1:0]   ld_mplr,
   output logic [3*W-1:0] acc_nxt,
   output logic           mplr_zero
);

   // Multiplicand is kept 3W wide so a 2W-bit a^2 survives W-1 left shifts.
   logic [3*W-1:0] mcand;
   logic [3*W-1:0] acc;
   logic [W-1:0]   mplr;

   assign acc_nxt   = acc + (mplr[0] ? mcand : '0);
   assign mplr_zero = (mplr[W-1:1] == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
      end else if (load) begin
         mcand <= ld_mcand;
         mplr  <= ld_mplr;
         acc   <= '0;
      end else if (step) begin
         acc   <= acc_nxt;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
      end
   end

endmodule

// File: rtl/fun_inv.sv
// Computes y = a^3 + b^2 with one shared shift-add multiplier over three phases.
// Optional FUN_INV_EARLY_EXIT_EN: a phase stops once the shifted multiplier is zero.
module fun_inv
   import fun_pkg::*;
#(
   parameter int W = FUN_W
)
(
   input  logic clk_i,
   input  logic rst_i,
   fun_inv_if.slave bus
);

   localparam int CW = $clog2(W) + 1;

   logic [2:0]     state, state_nxt;
   logic [W-1:0]   a_r;
   logic [2*W-1:0] sq;
   logic [3*W-1:0] cu;
   logic [3*W:0]   y_r;
   logic [CW-1:0]  cnt;
   logic [3*W-1:0] acc_nxt;
   logic [3*W-1:0] ld_mcand;
   logic [W-1:0]   ld_mplr;
   logic           mplr_zero, last_step, load, step;

`ifdef FUN_INV_EARLY_EXIT_EN
   assign last_step = mplr_zero || (cnt == CW'(W - 1));
`else
   assign last_step = (cnt == CW'(W - 1));
`endif

   mul_shadd #(.W(W)) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (load),
      .step      (step),
      .ld_mcand  (ld_mcand),
      .ld_mplr   (ld_mplr),
      .acc_nxt   (acc_nxt),
      .mplr_zero (mplr_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_i) state_nxt = SQ_B;
         SQ_B:    if (last_step)   state_nxt = SQ_A;
         SQ_A:    if (last_step)   state_nxt = CU_A;
         CU_A:    if (last_step)   state_nxt = ADD;
         ADD:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The last step of a phase reloads the multiplier from the combinational step result.
   always_comb begin
      load     = 1'b0;
      step     = 1'b0;
      ld_mcand = '0;
      ld_mplr  = '0;
      case (state)
         IDLE: if (bus.start_i) begin
            load     = 1'b1;
            ld_mcand = {{(2*W){1'b0}}, bus.b_bi};
            ld_mplr  = bus.b_bi;
         end
         SQ_B: begin
            step = 1'b1;
            if (last_step) begin
               load     = 1'b1;
               ld_mcand = {{(2*W){1'b0}}, a_r};
               ld_mplr  = a_r;
            end
         end
         SQ_A: begin
            step = 1'b1;
            if (last_step) begin
               load     = 1'b1;
               ld_mcand = {{W{1'b0}}, acc_nxt[2*W-1:0]};
               ld_mplr  = a_r;
            end
         end
         CU_A:    step = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_r <= '0;
         sq  <= '0;
         cu  <= '0;
         y_r <= '0;
         cnt <= '0;
      end else begin
         if (state == IDLE && bus.start_i) begin
            a_r <= bus.a_bi;
            y_r <= '0;
            cnt <= '0;
         end
         if (step) cnt <= last_step ? '0 : cnt + 1'b1;
         if (state == SQ_B && last_step) sq <= acc_nxt[2*W-1:0];
         if (state == CU_A && last_step) cu <= acc_nxt;
         if (state == ADD) y_r <= {1'b0, cu} + {{(W+1){1'b0}}, sq};
      end
   end

   assign bus.busy_o = (state != IDLE);
   assign bus.y_bo   = y_r;

endmodule

// File: tb/tb_fun_inv.sv
// Bench for fun_inv: cycle-level reference model plus directed literal checks.
module tb_fun_inv;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   fun_inv_if #(.W(W)) bus ();

   fun_inv #(.W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   function automatic int phase_steps(input int x);
`ifdef FUN_INV_EARLY_EXIT_EN
      int n = 0;
      if (x == 0) return 1;
      while (x != 0) begin n++; x = x >> 1; end
      return n;
`else
      return W;
`endif
   endfunction

   function automatic int model_lat(input int a, input int b);
      return phase_steps(b) + 2 * phase_steps(a) + 1;
   endfunction

   function automatic longint model_y(input int a, input int b);
      return longint'(a) * a * a + longint'(b) * b;
   endfunction

   // Reference: remaining busy cycles and the value y_bo must show.
   int     rem = 0;
   longint my = 0;
   longint pend = 0;
   bit     armed = 0;

   always @(posedge clk) begin
      armed = 1;
      if (rst) begin
         rem = 0;
         my  = 0;
      end else if (rem == 0) begin
         if (bus.start_i) begin
            rem  = model_lat(int'(bus.a_bi), int'(bus.b_bi));
            pend = model_y(int'(bus.a_bi), int'(bus.b_bi));
            my   = 0;
         end
      end else begin
         rem--;
         if (rem == 0) my = pend;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("cyc_busy", longint'(bus.busy_o), longint'(rem != 0));
         check("cyc_y", longint'(bus.y_bo), my);
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy_o && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) check("timeout", 1, 0);
   endtask

   task automatic run_op(input int a, input int b, input longint exp_y, input int exp_lat);
      int n;
      @(negedge clk);
      bus.a_bi    = W'(a);
      bus.b_bi    = W'(b);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_idle(n);
      check($sformatf("lat_%0d_%0d", a, b), n, exp_lat);
      check($sformatf("y_%0d_%0d", a, b), longint'(bus.y_bo), exp_y);
   endtask

   initial begin
      int n;
      int fixed_lat;
      fixed_lat   = 3 * W + 1;
      bus.a_bi    = '0;
      bus.b_bi    = '0;
      bus.start_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", longint'(bus.busy_o), 0);
      check("rst_y", longint'(bus.y_bo), 0);

      run_op(2, 3, 17, 25 - (fixed_lat - model_lat(2, 3)));
      run_op(255, 255, 16646400, 25);
`ifdef FUN_INV_EARLY_EXIT_EN
      run_op(0, 0, 0, 4);
      run_op(4, 1, 65, 8);
      run_op(1, 1, 2, 4);
`else
      run_op(0, 0, 0, 25);
      run_op(4, 1, 65, 25);
      run_op(1, 1, 2, 25);
`endif

      // Start while busy, with operand inputs changing, must be ignored.
      @(negedge clk);
      bus.a_bi = 8'd2; bus.b_bi = 8'd3; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      bus.a_bi = 8'd5; bus.b_bi = 8'd5; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0; bus.a_bi = 8'd6; bus.b_bi = 8'd6;
      wait_idle(n);
      check("ignore_y", longint'(bus.y_bo), 17);
      run_op(5, 5, 150, model_lat(5, 5));

      // Reset mid-operation.
      @(negedge clk);
      bus.a_bi = 8'd7; bus.b_bi = 8'd9; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", longint'(bus.busy_o), 0);
      check("midrst_y", longint'(bus.y_bo), 0);
`ifdef FUN_INV_EARLY_EXIT_EN
      run_op(3, 4, 43, 8);
`else
      run_op(3, 4, 43, 25);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
